// File: rtl/rst_seq_sonata.sv
// Staged reset sequencer: waits for a stable PLL lock, holds both resets, then
// releases the peripheral domain ahead of the core domain. Aborts restart the sequence.
module rst_seq_sonata #(
    parameter int SyncStages       = 2,
    parameter int LockStableCycles = 1024,
    parameter int ResetHoldCycles  = 16,
    parameter int StageGapCycles   = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pll_locked_i,
    input  logic       ext_rst_req_i,
    input  logic       sw_rst_req_i,
    output logic       rst_periph_o,
    output logic       rst_core_o,
    output logic       ready_o,
    output logic [1:0] rst_cause_o,
    output logic [7:0] lock_lost_cnt_o
);

    localparam int MaxA   = (LockStableCycles > ResetHoldCycles) ? LockStableCycles : ResetHoldCycles;
    localparam int MaxCnt = (MaxA > StageGapCycles) ? MaxA : StageGapCycles;
    localparam int CntW   = $clog2(MaxCnt + 1);

    localparam logic [CntW-1:0] LockLast = CntW'(LockStableCycles - 1);
    localparam logic [CntW-1:0] HoldLast = CntW'(ResetHoldCycles - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(StageGapCycles - 1);

    typedef enum logic [1:0] {WAIT_LOCK, HOLD, REL_PERIPH, RUN} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        cause_q, cause_d;
    logic [7:0]        lost_q;
    logic              periph_q, periph_d;
    logic              core_q, core_d;
    logic              ready_q, ready_d;
    logic [SyncStages-1:0] lock_sync_q, ext_sync_q;
    logic              lock_prev_q;
    logic              lock_s, ext_s;

    assign lock_s = lock_sync_q[SyncStages-1];
    assign ext_s  = ext_sync_q[SyncStages-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_sync_q <= '0;
            ext_sync_q  <= '0;
            lock_prev_q <= 1'b0;
            lost_q      <= 8'd0;
        end else begin
            lock_sync_q <= {lock_sync_q[SyncStages-2:0], pll_locked_i};
            ext_sync_q  <= {ext_sync_q[SyncStages-2:0], ext_rst_req_i};
            lock_prev_q <= lock_s;
            if (lock_prev_q && !lock_s && lost_q != 8'hFF)
                lost_q <= lost_q + 8'd1;
        end
    end

    // State register; the reset outputs are registered from the next state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= WAIT_LOCK;
            cnt_q    <= '0;
            cause_q  <= 2'd0;
            periph_q <= 1'b1;
            core_q   <= 1'b1;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cause_q  <= cause_d;
            periph_q <= periph_d;
            core_q   <= core_d;
            ready_q  <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        if (state_q != WAIT_LOCK && !lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            cause_d = 2'd1;
        end else if ((state_q == REL_PERIPH || state_q == RUN) && ext_s) begin
            state_d = HOLD;
            cnt_d   = '0;
            cause_d = 2'd2;
        end else if (state_q == RUN && sw_rst_req_i) begin
            state_d = HOLD;
            cnt_d   = '0;
            cause_d = 2'd3;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (!lock_s || ext_s) begin
                        cnt_d = '0;
                    end else if (cnt_q == LockLast) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                HOLD: begin
                    // button still held here simply restarts the hold window
                    if (ext_s) begin
                        cnt_d = '0;
                    end else if (cnt_q == HoldLast) begin
                        state_d = REL_PERIPH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                REL_PERIPH: begin
                    if (cnt_q == GapLast) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: cnt_d = '0;
            endcase
        end
    end

    always_comb begin
        periph_d = (state_d == WAIT_LOCK) || (state_d == HOLD);
        core_d   = (state_d != RUN);
        ready_d  = (state_d == RUN);
    end

    assign rst_periph_o    = periph_q;
    assign rst_core_o      = core_q;
    assign ready_o         = ready_q;
    assign rst_cause_o     = cause_q;
    assign lock_lost_cnt_o = lost_q;

endmodule

// File: tb/tb_rst_seq_sonata.sv
// Directed bench for rst_seq_sonata with short sequencing parameters.
module tb_rst_seq_sonata;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       pll_locked_i = 1'b0;
    logic       ext_rst_req_i = 1'b0;
    logic       sw_rst_req_i = 1'b0;
    logic       rst_periph_o, rst_core_o, ready_o;
    logic [1:0] rst_cause_o;
    logic [7:0] lock_lost_cnt_o;

    int n_cmp = 0;
    int n_err = 0;
    int n;

    rst_seq_sonata #(
        .SyncStages(2), .LockStableCycles(32), .ResetHoldCycles(4), .StageGapCycles(3)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .pll_locked_i(pll_locked_i),
        .ext_rst_req_i(ext_rst_req_i), .sw_rst_req_i(sw_rst_req_i),
        .rst_periph_o(rst_periph_o), .rst_core_o(rst_core_o), .ready_o(ready_o),
        .rst_cause_o(rst_cause_o), .lock_lost_cnt_o(lock_lost_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    // ticks until the selected reset (0 periph, 1 core) reads lvl; -1 on timeout
    task automatic wait_lvl(input int sel, input logic lvl, input int bound, output int cnt);
        cnt = -1;
        for (int i = 1; i <= bound; i++) begin
            tick();
            if (((sel == 0) ? rst_periph_o : rst_core_o) == lvl) begin
                cnt = i;
                break;
            end
        end
    endtask

    task automatic pulse_sw();
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
    endtask

    logic prev_p = 1'b1, prev_c = 1'b1;
    always @(negedge clk_i) begin
        chk("order", {31'd0, (!rst_core_o && rst_periph_o)}, 0);
        chk("same_edge", {31'd0, (prev_p && prev_c && !rst_periph_o && !rst_core_o)}, 0);
        prev_p = rst_periph_o;
        prev_c = rst_core_o;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ticks(3);
        chk("rst_periph", rst_periph_o, 1);
        chk("rst_core", rst_core_o, 1);
        chk("rst_ready", ready_o, 0);
        chk("rst_cause", rst_cause_o, 0);
        chk("rst_cnt", lock_lost_cnt_o, 0);

        // power-up
        pll_locked_i = 1'b1;
        rst_i = 1'b0;
        wait_lvl(0, 1'b0, 200, n);
        chk("pu_periph_rel", n, 38);
        wait_lvl(1, 1'b0, 50, n);
        chk("pu_core_gap", n, 3);
        chk("pu_ready", ready_o, 1);
        chk("pu_cause", rst_cause_o, 0);
        chk("pu_cnt", lock_lost_cnt_o, 0);

        // lock flap during the lock count
        rst_i = 1'b1;
        ticks(2);
        rst_i = 1'b0;
        ticks(20);
        pll_locked_i = 1'b0;
        tick();
        pll_locked_i = 1'b1;
        chk("flap_periph_held", rst_periph_o, 1);
        wait_lvl(0, 1'b0, 200, n);
        chk("flap_rel", 21 + n, 59);
        chk("flap_cnt", lock_lost_cnt_o, 1);
        wait_lvl(1, 1'b0, 50, n);
        chk("flap_core_gap", n, 3);

        // lock loss in RUN
        pll_locked_i = 1'b0;
        ticks(2);
        chk("ll_ready_still", ready_o, 1);
        tick();
        chk("ll_periph", rst_periph_o, 1);
        chk("ll_core", rst_core_o, 1);
        chk("ll_ready", ready_o, 0);
        chk("ll_cause", rst_cause_o, 1);
        chk("ll_cnt", lock_lost_cnt_o, 2);
        pll_locked_i = 1'b1;
        wait_lvl(0, 1'b0, 200, n);
        chk("ll_rerun", n, 38);
        wait_lvl(1, 1'b0, 50, n);
        chk("ll_core_gap", n, 3);

        // software reset in RUN, second pulse during HOLD ignored
        pulse_sw();
        chk("sw_periph", rst_periph_o, 1);
        chk("sw_core", rst_core_o, 1);
        chk("sw_ready", ready_o, 0);
        chk("sw_cause", rst_cause_o, 3);
        pulse_sw();
        wait_lvl(0, 1'b0, 50, n);
        chk("sw_rel", n, 3);
        chk("sw_cause_kept", rst_cause_o, 3);
        wait_lvl(1, 1'b0, 50, n);
        chk("sw_core_gap", n, 3);

        // button pressed in REL_PERIPH
        pulse_sw();
        wait_lvl(0, 1'b0, 50, n);
        chk("btn_enter_rel", n, 4);
        ext_rst_req_i = 1'b1;
        ticks(3);
        chk("btn_periph", rst_periph_o, 1);
        chk("btn_core", rst_core_o, 1);
        chk("btn_cause", rst_cause_o, 2);
        ticks(7);
        ext_rst_req_i = 1'b0;
        wait_lvl(0, 1'b0, 50, n);
        chk("btn_rel", n, 6);
        wait_lvl(1, 1'b0, 50, n);
        chk("btn_core_gap", n, 3);

        // lock loss together with sw
        pll_locked_i = 1'b0;
        ticks(2);
        pulse_sw();
        chk("sim_ls_core", rst_core_o, 1);
        chk("sim_ls_periph", rst_periph_o, 1);
        chk("sim_ls_cause", rst_cause_o, 1);
        chk("sim_ls_cnt", lock_lost_cnt_o, 3);
        pll_locked_i = 1'b1;
        wait_lvl(0, 1'b0, 200, n);
        chk("sim_ls_rerun", n, 38);
        wait_lvl(1, 1'b0, 50, n);
        chk("sim_ls_core_gap", n, 3);

        // ext together with sw
        ext_rst_req_i = 1'b1;
        ticks(2);
        pulse_sw();
        ext_rst_req_i = 1'b0;
        chk("sim_es_periph", rst_periph_o, 1);
        chk("sim_es_cause", rst_cause_o, 2);
        wait_lvl(0, 1'b0, 50, n);
        chk("sim_es_rel", n, 6);
        wait_lvl(1, 1'b0, 50, n);
        chk("sim_es_core_gap", n, 3);

        // saturate the lock-loss counter
        for (int i = 0; i < 300; i++) begin
            pll_locked_i = 1'b0;
            tick();
            pll_locked_i = 1'b1;
            tick();
        end
        ticks(3);
        chk("sat_cnt", lock_lost_cnt_o, 255);

        // rst_i in REL_PERIPH
        wait_lvl(0, 1'b0, 200, n);
        chk("mid_reach_rel", {31'd0, (n > 0)}, 1);
        rst_i = 1'b1;
        tick();
        chk("mid_periph", rst_periph_o, 1);
        chk("mid_core", rst_core_o, 1);
        chk("mid_ready", ready_o, 0);
        chk("mid_cause", rst_cause_o, 0);
        chk("mid_cnt", lock_lost_cnt_o, 0);
        rst_i = 1'b0;
        tick();
        chk("post_periph", rst_periph_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
